// File: rtl/secuenciador_vga.sv
// VGA pixel/line timing sequencer: counters, sync/blank decode, and the
// line-buffer fetch handshake with swap pulses and sticky underrun flag.
module secuenciador_vga #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       en_pixel,
    input  logic       listo,
    input  logic       limpiar_error,
    output logic [9:0] columna,
    output logic [9:0] linea_num,
    output logic       hsync,
    output logic       vsync,
    output logic       n_blank,
    output logic       pedir,
    output logic [8:0] linea_pedida,
    output logic       intercambiar,
    output logic       inicio_cuadro,
    output logic       subdesbordamiento
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_ULT    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ULT    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_VIS_U  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_U  = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_INI   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_FIN   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_INI   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_FIN   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {ESPERA, PIDE, SERVIDO} estado_t;

    logic [9:0] r_columna, r_linea;
    logic [8:0] r_linea_pedida;
    logic       r_intercambiar, r_inicio_cuadro, r_subdesb;
    estado_t    r_estado, w_estado_sig;

    logic       w_fin_linea, w_fin_cuadro, w_inicio_pedido, w_sig_visible;
    logic [8:0] w_linea_sig;
    logic       w_cargar, w_swap, w_underrun;

    assign w_fin_linea     = en_pixel && (r_columna == H_ULT);
    assign w_fin_cuadro    = w_fin_linea && (r_linea == V_ULT);
    assign w_sig_visible   = (r_linea < V_VIS_U) || (r_linea == V_ULT);
    assign w_linea_sig     = (r_linea == V_ULT) ? 9'd0 : 9'(r_linea + 10'd1);
    assign w_inicio_pedido = en_pixel && (r_columna == H_VIS_U) && w_sig_visible;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_columna <= '0;
            r_linea   <= '0;
        end else if (en_pixel) begin
            if (w_fin_linea) begin
                r_columna <= '0;
                r_linea   <= w_fin_cuadro ? 10'd0 : r_linea + 10'd1;
            end else begin
                r_columna <= r_columna + 10'd1;
            end
        end
    end

    // Fetch handshake: one outstanding request per visible line, resolved at the wrap.
    always_comb begin
        w_estado_sig = r_estado;
        w_cargar     = 1'b0;
        w_swap       = 1'b0;
        w_underrun   = 1'b0;
        case (r_estado)
            ESPERA: begin
                if (w_inicio_pedido) begin
                    w_estado_sig = PIDE;
                    w_cargar     = 1'b1;
                end
            end
            PIDE: begin
                if (w_fin_linea) begin
                    w_estado_sig = ESPERA;
                    w_swap       = listo;
                    w_underrun   = !listo;
                end else if (listo) begin
                    w_estado_sig = SERVIDO;
                end
            end
            SERVIDO: begin
                if (w_fin_linea) begin
                    w_estado_sig = ESPERA;
                    w_swap       = 1'b1;
                end
            end
            default: w_estado_sig = ESPERA;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_estado        <= ESPERA;
            r_linea_pedida  <= '0;
            r_intercambiar  <= 1'b0;
            r_inicio_cuadro <= 1'b0;
            r_subdesb       <= 1'b0;
        end else begin
            r_estado        <= w_estado_sig;
            r_intercambiar  <= w_swap;
            r_inicio_cuadro <= w_fin_cuadro;
            // A new underrun wins over a simultaneous clear.
            r_subdesb       <= w_underrun || (r_subdesb && !limpiar_error);
            if (w_cargar)
                r_linea_pedida <= w_linea_sig;
        end
    end

    assign columna           = r_columna;
    assign linea_num         = r_linea;
    assign hsync             = !((r_columna >= HS_INI) && (r_columna < HS_FIN));
    assign vsync             = !((r_linea >= VS_INI) && (r_linea < VS_FIN));
    assign n_blank           = (r_columna < H_VIS) && (r_linea < V_VIS);
    assign pedir             = (r_estado == PIDE);
    assign linea_pedida      = r_linea_pedida;
    assign intercambiar      = r_intercambiar;
    assign inicio_cuadro     = r_inicio_cuadro;
    assign subdesbordamiento = r_subdesb;

endmodule

// File: tb/tb_secuenciador_vga.sv
// Scoreboarded random bench for secuenciador_vga on a shrunk raster so that
// several whole frames, edge lines and handshake corner cases fit in the run.
module tb_secuenciador_vga;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       en_pixel = 1'b0, listo = 1'b0, limpiar_error = 1'b0;
    logic [9:0] columna, linea_num;
    logic       hsync, vsync, n_blank, pedir;
    logic [8:0] linea_pedida;
    logic       intercambiar, inicio_cuadro, subdesbordamiento;

    secuenciador_vga #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .n_reset(n_reset), .en_pixel(en_pixel), .listo(listo),
        .limpiar_error(limpiar_error), .columna(columna), .linea_num(linea_num),
        .hsync(hsync), .vsync(vsync), .n_blank(n_blank), .pedir(pedir),
        .linea_pedida(linea_pedida), .intercambiar(intercambiar),
        .inicio_cuadro(inicio_cuadro), .subdesbordamiento(subdesbordamiento)
    );

    always #5 clk = ~clk;

    typedef struct {
        int col, lin, lp;
        bit hs, vs, nb, ped, sw, ic, sub;
    } exp_t;

    exp_t q[$];
    int n_checks = 0, n_fail = 0;
    int n_swaps = 0, n_unders = 0, n_frames = 0;

    // Reference model: pixel index within the frame plus request bookkeeping.
    int m_p, m_lp;
    bit m_pend, m_serv, m_sub;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_lp = 0; m_pend = 0; m_serv = 0; m_sub = 0;
    endtask

    // Applies one clock of inputs to the model and queues the state it predicts.
    task automatic model_step(input bit en, input bit ls, input bit clr);
        int c, l;
        bit wrap, sw, und, ic;
        exp_t e;
        c = m_p % HT;
        l = m_p / HT;
        wrap = en && (c == HT - 1);
        sw = 0; und = 0;
        if (m_pend) begin
            if (wrap) begin
                if (m_serv || ls) sw = 1; else und = 1;
                m_pend = 0;
            end else if (ls) m_serv = 1;
        end else if (en && c == HV - 1 && (l < VV - 1 || l == VT - 1)) begin
            m_pend = 1; m_serv = 0;
            m_lp = (l == VT - 1) ? 0 : l + 1;
        end
        ic = wrap && (l == VT - 1);
        m_sub = und || (m_sub && !clr);
        if (en) m_p = (m_p + 1) % FRAME;
        n_swaps += sw; n_unders += und; n_frames += ic;
        e.col = m_p % HT;
        e.lin = m_p / HT;
        e.hs  = !(e.col >= HV + HF && e.col < HV + HF + HS);
        e.vs  = !(e.lin >= VV + VF && e.lin < VV + VF + VS);
        e.nb  = (e.col < HV) && (e.lin < VV);
        e.ped = m_pend && !m_serv;
        e.lp  = m_lp;
        e.sw  = sw; e.ic = ic; e.sub = m_sub;
        q.push_back(e);
    endtask

    // mode 0: free run, listo=1; 1: random; 2: listo only on the wrap edge;
    // 3: listo never, clear on the underrun edge; 4: half-rate enable; 5: listo never.
    task automatic drive(input int mode, input int cyc);
        bit en, ls, clr, wrap_next;
        @(negedge clk);
        en = 1; ls = 0; clr = 0;
        case (mode)
            0: ls = 1;
            1: begin en = ($urandom % 4) != 0; ls = ($urandom % 8) == 0; clr = ($urandom % 16) == 0; end
            4: begin en = cyc[0]; ls = ($urandom % 3) == 0; end
            default: ;
        endcase
        wrap_next = en && (m_p % HT == HT - 1);
        if (mode == 2) ls = wrap_next;
        if (mode == 3) clr = wrap_next && m_pend && !m_serv;
        en_pixel = en; listo = ls; limpiar_error = clr;
        model_step(en, ls, clr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " columna"}, columna, 0);
        check({tag, " linea_num"}, linea_num, 0);
        check({tag, " sync/blank"}, {hsync, vsync, n_blank}, 3'b111);
        check({tag, " pedir"}, pedir, 0);
        check({tag, " linea_pedida"}, linea_pedida, 0);
        check({tag, " pulses/flag"}, {intercambiar, inicio_cuadro, subdesbordamiento}, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("columna", columna, e.col);
                check("linea_num", linea_num, e.lin);
                check("hsync", hsync, e.hs);
                check("vsync", vsync, e.vs);
                check("n_blank", n_blank, e.nb);
                check("pedir", pedir, e.ped);
                check("linea_pedida", linea_pedida, e.lp);
                check("intercambiar", intercambiar, e.sw);
                check("inicio_cuadro", inicio_cuadro, e.ic);
                check("subdesbordamiento", subdesbordamiento, e.sub);
            end
        end
    end

    initial begin : stim
        int guard;
        model_reset();
        #1 check_reset_values("power-on");
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 2 * FRAME + 10; i++) drive(0, i);
        check("free-run swaps per 2 frames", n_swaps, 2 * VV);
        check("free-run frame pulses", n_frames, 2);
        check("free-run underruns", n_unders, 0);
        for (int i = 0; i < FRAME; i++) drive(2, i);
        for (int i = 0; i < FRAME; i++) drive(3, i);
        for (int i = 0; i < 3 * FRAME; i++) drive(1, i);
        n_frames = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) drive(4, i);
        check("half-rate frame pulses", n_frames, 1);

        // Reset while a request is outstanding.
        guard = 0;
        do begin drive(5, guard); guard++; end while (!(m_pend && !m_serv) && guard < 4 * FRAME);
        check("reached pending request", m_pend, 1);
        @(negedge clk);
        #2 n_reset = 1'b0;
        #1 check_reset_values("async reset");
        for (int i = 0; i < 3; i++) begin
            en_pixel = 1'b1; listo = 1'b1;
            @(negedge clk);
            check_reset_values("held reset");
        end
        en_pixel = 1'b0; listo = 1'b0; limpiar_error = 1'b0;
        n_reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) drive(1, i);

        @(negedge clk);
        en_pixel = 1'b0; listo = 1'b0; limpiar_error = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
        check("scoreboard drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
